// File: rtl/mmio_wb_arbiter.sv
// Two-master round-robin WISHBONE arbiter for the MMIO slave port, with a
// per-access watchdog that answers a hung strobe with a one-cycle error ack.
module mmio_wb_arbiter #(
  parameter int unsigned       ADDR_W   = 21,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_dat_w,
  output logic [DATA_W-1:0] m0_dat_r,
  output logic              m0_ack,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_dat_w,
  output logic [DATA_W-1:0] m1_dat_r,
  output logic              m1_ack,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_dat_w,
  input  logic [DATA_W-1:0] s_dat_r,
  input  logic              s_ack,
  output logic [1:0]        grant,
  output logic              err_flag,
  output logic              err_master,
  input  logic              err_clr
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, TOUT} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             tout_mst_q, tout_mst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_flag_q, err_flag_d;
  logic             err_master_q, err_master_d;

  // cur is the master that owns the port, or the one owed an error ack in TOUT.
  logic              cur;
  logic              cur_cyc, cur_stb, cur_we, oth_cyc;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_dat_w;
  logic              ack_int;
  logic [DATA_W-1:0] dat_r_int;

  function automatic state_e gnt_of(input logic m);
    return m ? GNT1 : GNT0;
  endfunction

  assign cur       = (state_q == TOUT) ? tout_mst_q : (state_q == GNT1);
  assign cur_cyc   = cur ? m1_cyc   : m0_cyc;
  assign cur_stb   = cur ? m1_stb   : m0_stb;
  assign cur_we    = cur ? m1_we    : m0_we;
  assign cur_addr  = cur ? m1_addr  : m0_addr;
  assign cur_dat_w = cur ? m1_dat_w : m0_dat_w;
  assign oth_cyc   = cur ? m0_cyc   : m1_cyc;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    last_d       = last_q;
    tout_mst_d   = tout_mst_q;
    cnt_d        = '0;
    err_flag_d   = err_flag_q & ~err_clr;
    err_master_d = err_master_q;
    grant        = 2'b00;
    s_cyc        = 1'b0;
    s_stb        = 1'b0;
    s_we         = 1'b0;
    s_addr       = '0;
    s_dat_w      = '0;
    ack_int      = 1'b0;
    dat_r_int    = '0;

    unique case (state_q)
      IDLE: begin
        if (m0_cyc && (!m1_cyc || last_q)) state_d = GNT0;
        else if (m1_cyc)                   state_d = GNT1;
      end
      GNT0, GNT1: begin
        grant     = cur ? 2'b10 : 2'b01;
        s_cyc     = cur_cyc;
        s_stb     = cur_stb;
        s_we      = cur_we;
        s_addr    = cur_addr;
        s_dat_w   = cur_dat_w;
        ack_int   = s_ack;
        dat_r_int = s_dat_r;
        if (!cur_cyc) begin
          state_d = oth_cyc ? gnt_of(!cur) : IDLE;
        end else if (cur_stb && !s_ack) begin
          if (cnt_q == CNT_LAST) begin
            state_d      = TOUT;
            tout_mst_d   = cur;
            err_flag_d   = 1'b1;
            err_master_d = cur;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      TOUT: begin
        // Bus is withdrawn from the slave; a late s_ack here is ignored.
        grant        = cur ? 2'b10 : 2'b01;
        ack_int      = 1'b1;
        dat_r_int    = ERR_DATA;
        err_flag_d   = 1'b1;
        err_master_d = cur;
        if (cur_cyc)      state_d = gnt_of(cur);
        else if (oth_cyc) state_d = gnt_of(!cur);
        else              state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == GNT0)      last_d = 1'b0;
    else if (state_d == GNT1) last_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      tout_mst_q   <= 1'b0;
      cnt_q        <= '0;
      err_flag_q   <= 1'b0;
      err_master_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      tout_mst_q   <= tout_mst_d;
      cnt_q        <= cnt_d;
      err_flag_q   <= err_flag_d;
      err_master_q <= err_master_d;
    end
  end

  assign m0_ack     = ack_int & ~cur;
  assign m1_ack     = ack_int &  cur;
  assign m0_dat_r   = cur ? '0 : dat_r_int;
  assign m1_dat_r   = cur ? dat_r_int : '0;
  assign err_flag   = err_flag_q;
  assign err_master = err_master_q;

endmodule

// File: tb/tb_mmio_wb_arbiter.sv
// Bench for mmio_wb_arbiter: cycle vector table, hand-written timeout/reset
// sequences, and randomized traffic against a transaction-level reference model.
module tb_mmio_wb_arbiter;

  localparam int          ADDR_W   = 21;
  localparam int          DATA_W   = 32;
  localparam int          TIMEOUT  = 8;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic              clk;
  logic              rst_n;
  logic              m0_cyc, m0_stb, m0_we, m0_ack;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_dat_w, m0_dat_r;
  logic              m1_cyc, m1_stb, m1_we, m1_ack;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_dat_w, m1_dat_r;
  logic              s_cyc, s_stb, s_we, s_ack;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_dat_w, s_dat_r;
  logic [1:0]        grant;
  logic              err_flag, err_master, err_clr;

  mmio_wb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r), .m0_ack(m0_ack),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r), .m1_ack(m1_ack),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr),
    .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack),
    .grant(grant), .err_flag(err_flag), .err_master(err_master), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = 21'h00100; m0_dat_w = 32'hA0A0_0000;
    m1_cyc = 0; m1_stb = 0; m1_we = 1; m1_addr = 21'h00200; m1_dat_w = 32'hB1B1_0000;
    s_ack = 0; s_dat_r = '0; err_clr = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    step();
    step();
    rst_n = 1;
  endtask

  // ---------------- cycle vector table ----------------
  typedef struct {
    logic [4:0]  in;    // {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack}
    logic [31:0] dat;   // s_dat_r
    logic [1:0]  grant;
    logic [4:0]  ex;    // {s_cyc, s_stb, s_we, m0_ack, m1_ack}
    logic [31:0] d0;
    logic [31:0] d1;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [4:0] in, input logic [31:0] dat, input logic [1:0] g,
                              input logic [4:0] ex, input logic [31:0] d0, input logic [31:0] d1);
    vec_t v;
    v.in = in; v.dat = dat; v.grant = g; v.ex = ex; v.d0 = d0; v.d1 = d1;
    return v;
  endfunction

  task automatic fill_vectors();
    // three contentions: m0, handover to m1, then m0, then m1
    vecs[0]  = mk(5'b11110, 32'h0,         2'b00, 5'b00000, 32'h0,         32'h0);
    vecs[1]  = mk(5'b11111, 32'h1111_0001, 2'b01, 5'b11010, 32'h1111_0001, 32'h0);
    vecs[2]  = mk(5'b00110, 32'h0,         2'b01, 5'b00000, 32'h0,         32'h0);
    vecs[3]  = mk(5'b00111, 32'h2222_0002, 2'b10, 5'b11101, 32'h0,         32'h2222_0002);
    vecs[4]  = mk(5'b00000, 32'h0,         2'b10, 5'b00100, 32'h0,         32'h0);
    vecs[5]  = mk(5'b11110, 32'h0,         2'b00, 5'b00000, 32'h0,         32'h0);
    vecs[6]  = mk(5'b11111, 32'h3333_0003, 2'b01, 5'b11010, 32'h3333_0003, 32'h0);
    vecs[7]  = mk(5'b00000, 32'h0,         2'b01, 5'b00000, 32'h0,         32'h0);
    vecs[8]  = mk(5'b11110, 32'h0,         2'b00, 5'b00000, 32'h0,         32'h0);
    vecs[9]  = mk(5'b11111, 32'h4444_0004, 2'b10, 5'b11101, 32'h0,         32'h4444_0004);
    vecs[10] = mk(5'b00000, 32'h0,         2'b10, 5'b00100, 32'h0,         32'h0);
    // m1 holds cyc over four writes while m0 waits
    vecs[11] = mk(5'b00110, 32'h0,         2'b00, 5'b00000, 32'h0,         32'h0);
    vecs[12] = mk(5'b11111, 32'h5555_0001, 2'b10, 5'b11101, 32'h0,         32'h5555_0001);
    vecs[13] = mk(5'b11100, 32'h0,         2'b10, 5'b10100, 32'h0,         32'h0);
    vecs[14] = mk(5'b11111, 32'h5555_0002, 2'b10, 5'b11101, 32'h0,         32'h5555_0002);
    vecs[15] = mk(5'b11111, 32'h5555_0003, 2'b10, 5'b11101, 32'h0,         32'h5555_0003);
    vecs[16] = mk(5'b11111, 32'h5555_0004, 2'b10, 5'b11101, 32'h0,         32'h5555_0004);
    vecs[17] = mk(5'b11000, 32'h0,         2'b10, 5'b00100, 32'h0,         32'h0);
    vecs[18] = mk(5'b11001, 32'h6666_0005, 2'b01, 5'b11010, 32'h6666_0005, 32'h0);
    vecs[19] = mk(5'b00000, 32'h0,         2'b01, 5'b00000, 32'h0,         32'h0);
    vecs[20] = mk(5'b00000, 32'h0,         2'b00, 5'b00000, 32'h0,         32'h0);
    // single m0 read, slave acks one cycle after the strobe
    vecs[21] = mk(5'b11000, 32'h0,         2'b00, 5'b00000, 32'h0,         32'h0);
    vecs[22] = mk(5'b11000, 32'h0,         2'b01, 5'b11000, 32'h0,         32'h0);
    vecs[23] = mk(5'b11001, 32'h1234_5678, 2'b01, 5'b11010, 32'h1234_5678, 32'h0);
    vecs[24] = mk(5'b00000, 32'h0,         2'b01, 5'b00000, 32'h0,         32'h0);
    vecs[25] = mk(5'b00000, 32'h0,         2'b00, 5'b00000, 32'h0,         32'h0);
  endtask

  // ---------------- reference model ----------------
  // Tracks who owns the port, who is owed an error ack, and how long the
  // current strobe has gone unanswered.
  int          mdl_owner, mdl_err_for, mdl_wait, mdl_last;
  logic        mdl_flag, mdl_errm;
  logic [1:0]  exp_grant;
  logic [55:0] exp_bus;
  logic [1:0]  exp_ack;
  logic [31:0] exp_dat [2];

  task automatic mdl_reset();
    mdl_owner = -1; mdl_err_for = -1; mdl_wait = 0; mdl_last = 1;
    mdl_flag = 0; mdl_errm = 0;
  endtask

  task automatic mdl_predict();
    logic [55:0] bus [2];
    bus[0] = {m0_cyc, m0_stb, m0_we, m0_addr, m0_dat_w};
    bus[1] = {m1_cyc, m1_stb, m1_we, m1_addr, m1_dat_w};
    exp_grant = '0; exp_bus = '0; exp_ack = '0; exp_dat[0] = '0; exp_dat[1] = '0;
    if (mdl_err_for >= 0) begin
      exp_grant[mdl_err_for] = 1'b1;
      exp_ack[mdl_err_for]   = 1'b1;
      exp_dat[mdl_err_for]   = ERR_DATA;
    end else if (mdl_owner >= 0) begin
      exp_grant[mdl_owner] = 1'b1;
      exp_bus              = bus[mdl_owner];
      exp_ack[mdl_owner]   = s_ack;
      exp_dat[mdl_owner]   = s_dat_r;
    end
  endtask

  task automatic mdl_advance();
    logic cyc [2];
    logic stb [2];
    int   nxt, err_nxt;
    cyc[0] = m0_cyc; cyc[1] = m1_cyc;
    stb[0] = m0_stb; stb[1] = m1_stb;
    nxt = -1; err_nxt = -1;
    if (mdl_err_for >= 0) begin
      mdl_flag = 1; mdl_errm = 1'(mdl_err_for);
      if (cyc[mdl_err_for])          nxt = mdl_err_for;
      else if (cyc[1 - mdl_err_for]) nxt = 1 - mdl_err_for;
      mdl_wait = 0;
    end else if (mdl_owner >= 0) begin
      if (!cyc[mdl_owner]) begin
        if (cyc[1 - mdl_owner]) nxt = 1 - mdl_owner;
        mdl_wait = 0;
      end else if (stb[mdl_owner] && !s_ack) begin
        if (mdl_wait == TIMEOUT - 1) begin
          err_nxt = mdl_owner; mdl_wait = 0;
          mdl_flag = 1; mdl_errm = 1'(mdl_owner);
        end else begin
          nxt = mdl_owner; mdl_wait++;
        end
      end else begin
        nxt = mdl_owner; mdl_wait = 0;
      end
    end else begin
      if (cyc[0] && cyc[1]) nxt = 1 - mdl_last;
      else if (cyc[0])      nxt = 0;
      else if (cyc[1])      nxt = 1;
      mdl_wait = 0;
    end
    if (mdl_err_for < 0 && err_nxt < 0 && err_clr) mdl_flag = 0;
    if (nxt >= 0) mdl_last = nxt;
    mdl_owner   = nxt;
    mdl_err_for = err_nxt;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   stb_cnt;
    logic seen;
    logic rc0, rc1;

    // reset state, with busy-looking inputs held during reset
    rst_n = 0;
    clear_inputs();
    m0_cyc = 1; m0_stb = 1; s_ack = 1; s_dat_r = 32'hFFFF_FFFF;
    step();
    step();
    check("reset_state",
          {grant, s_cyc, s_stb, s_we, s_addr, s_dat_w, m0_ack, m1_ack, m0_dat_r, m1_dat_r, err_flag, err_master},
          128'h0);
    do_reset();

    // table of cycle vectors
    fill_vectors();
    for (int i = 0; i < NVEC; i++) begin
      {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack} = vecs[i].in;
      s_dat_r = vecs[i].dat;
      #1;
      check($sformatf("vec%0d", i),
            {grant, s_cyc, s_stb, s_we, m0_ack, m1_ack, m0_dat_r, m1_dat_r},
            {vecs[i].grant, vecs[i].ex, vecs[i].d0, vecs[i].d1});
      step();
    end

    // m1 read to a silent slave: watchdog fires
    clear_inputs();
    m1_we = 0; m1_cyc = 1; m1_stb = 1;
    #1;
    check("tout_idle_grant", grant, 2'b00);
    step();
    stb_cnt = 0;
    seen    = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (m1_ack) seen = 1;
      else begin
        if (s_stb) stb_cnt++;
        step();
      end
    end
    check("tout_ack_seen", seen, 1'b1);
    check("tout_stb_cycles", stb_cnt, TIMEOUT);
    check("tout_err_data", m1_dat_r, ERR_DATA);
    check("tout_bus_off", {s_cyc, s_stb, m0_ack}, 3'b000);
    check("tout_err_flags", {err_flag, err_master}, 2'b11);
    m1_cyc = 0; m1_stb = 0;
    step();
    #1;
    check("tout_ack_once", {m1_ack, m0_ack, grant}, 4'b0000);
    check("tout_flag_sticky", {err_flag, err_master}, 2'b11);
    err_clr = 1;
    step();
    err_clr = 0;
    #1;
    check("err_clr_drops", {err_flag, err_master}, 2'b01);

    // err_clr held while an m0 timeout fires: set wins
    step();
    m0_cyc = 1; m0_stb = 1;
    step();
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    err_clr = 1;
    #1;
    check("race_last_stb", {s_stb, m0_ack}, 2'b10);
    step();
    #1;
    check("race_err_ack", {m0_ack, m0_dat_r}, {1'b1, ERR_DATA});
    m0_cyc = 0; m0_stb = 0;
    step();
    err_clr = 0;
    #1;
    check("race_flag_set", {err_flag, err_master}, 2'b10);

    // asynchronous reset in the middle of a granted m0 transfer
    step();
    m0_cyc = 1; m0_stb = 1; s_ack = 1; s_dat_r = 32'h7777_7777;
    step();
    #1;
    check("rst_pre_grant", {grant, s_cyc, m0_ack}, 4'b0111);
    rst_n = 0;
    #1;
    check("rst_async", {grant, s_cyc, s_stb, m0_ack, m0_dat_r, err_flag}, 39'h0);
    s_ack = 0;
    m1_cyc = 1; m1_stb = 1;
    step();
    rst_n = 1;
    step();
    #1;
    check("rst_contend_m0_wins", grant, 2'b01);
    rst_n = 0;
    clear_inputs();
    m1_cyc = 1; m1_stb = 1;
    step();
    rst_n = 1;
    step();
    #1;
    check("rst_m1_alone_wins", grant, 2'b10);

    // randomized traffic against the reference model
    do_reset();
    mdl_reset();
    rc0 = 0; rc1 = 0;
    for (int n = 0; n < 1500; n++) begin
      rc0 = rc0 ? ($urandom_range(5) != 0) : ($urandom_range(3) == 0);
      rc1 = rc1 ? ($urandom_range(5) != 0) : ($urandom_range(3) == 0);
      m0_cyc = rc0; m0_stb = rc0 && ($urandom_range(3) != 0); m0_we = 1'($urandom);
      m1_cyc = rc1; m1_stb = rc1 && ($urandom_range(3) != 0); m1_we = 1'($urandom);
      m0_addr = ADDR_W'($urandom); m0_dat_w = $urandom;
      m1_addr = ADDR_W'($urandom); m1_dat_w = $urandom;
      s_ack = ($urandom_range(5) == 0); s_dat_r = $urandom;
      err_clr = ($urandom_range(19) == 0);
      #1;
      mdl_predict();
      check($sformatf("rand%0d_grant_err", n), {grant, err_flag, err_master}, {exp_grant, mdl_flag, mdl_errm});
      check($sformatf("rand%0d_bus", n), {s_cyc, s_stb, s_we, s_addr, s_dat_w}, exp_bus);
      check($sformatf("rand%0d_m0", n), {m0_ack, m0_dat_r}, {exp_ack[0], exp_dat[0]});
      check($sformatf("rand%0d_m1", n), {m1_ack, m1_dat_r}, {exp_ack[1], exp_dat[1]});
      mdl_advance();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
